memory_stream_reader: RTL and testbench

MEMORY_STREAM_READER -- requirements
Module: memory_stream_reader

---
 rtl/memory_stream_reader.sv | 142 ++++++++++++++
 tb/tb_memory_stream_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stream_reader.sv
// Streams a block of words from a RAM with a 1-cycle read latency out over a valid/ready port.
// Optional: define READER_LOOP_EN to replay the block continuously until abort or reset.
module memory_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
`ifdef READER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_nx;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [CNT_WIDTH-1:0]   len_q;
  logic [CNT_WIDTH-1:0]   issue_cnt;
  logic                   inflight;
  logic                   inflight_last;
  logic [DATA_WIDTH-1:0]  skid_data;
  logic                   skid_valid;
  logic                   skid_last;

  logic                   pop_c;
  logic [1:0]             load_c;
  logic                   issue_c;
  logic                   issue_last_c;
  logic                   last_xfer_c;

  // Load counts words buffered after this edge's pop plus the read still returning.
  always_comb begin
    pop_c        = out_valid & out_ready;
    load_c       = 2'({1'b0, out_valid}) + 2'({1'b0, skid_valid})
                 - 2'({1'b0, pop_c}) + 2'({1'b0, inflight});
    issue_c      = (state == RUN) && (load_c < 2'd2);
    issue_last_c = issue_c && (issue_cnt == (len_q - CNT_WIDTH'(1)));
    last_xfer_c  = pop_c & out_last;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && (length != '0)) state_nx = RUN;
        RUN:     if (issue_last_c && !LOOP_EN) state_nx = DRAIN;
        DRAIN:   if (last_xfer_c) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Read issue, 2-deep output buffer (head register drives the port), status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      issue_cnt     <= '0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      skid_data     <= '0;
      skid_valid    <= 1'b0;
      skid_last     <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= !abort && (((state == IDLE) && start && (length == '0)) || last_xfer_c);
      if ((state == IDLE) && start && !abort) begin
        base_q    <= base_addr;
        len_q     <= length;
        issue_cnt <= '0;
      end
      if (abort) begin
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
        out_valid     <= 1'b0;
        out_last      <= 1'b0;
        skid_valid    <= 1'b0;
      end else begin
        inflight      <= issue_c;
        inflight_last <= issue_last_c;
        if (issue_c) begin
          rd_addr   <= base_q + issue_cnt[ADDR_WIDTH-1:0];
          issue_cnt <= (LOOP_EN && issue_last_c) ? '0 : issue_cnt + CNT_WIDTH'(1);
        end
        if (!out_valid || out_ready) begin
          if (skid_valid) begin
            out_data   <= skid_data;
            out_last   <= skid_last;
            out_valid  <= 1'b1;
            skid_valid <= inflight;
            if (inflight) begin
              skid_data <= rd_data;
              skid_last <= inflight_last;
            end
          end else begin
            out_valid <= inflight;
            out_last  <= inflight & inflight_last;
            if (inflight) out_data <= rd_data;
          end
        end else if (inflight) begin
          skid_data  <= rd_data;
          skid_last  <= inflight_last;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed self-checking bench for memory_stream_reader (single-pass build, or loop build with READER_LOOP_EN).
module tb_memory_stream_reader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, abort, out_ready;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic [3:0] rd_addr;
  logic [7:0] rd_data, out_data;
  logic       out_valid, out_last, busy, done;

  logic [7:0] mem [16];
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_data [16];
  logic       got_last [16];
  int         got_cyc  [16];
  int         got_n, done_seen;
  logic [3:0] addr_log [$];

  memory_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // RAM read data is sampled by the reader on the edge after rd_addr is launched.
  assign rd_data = mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_xfer(input logic [3:0] b, input logic [4:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle);
    int         cyc;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [3:0] last_addr;
    got_n = 0; done_seen = 0; cyc = 0; prev_stall = 0; prev_data = '0;
    addr_log.delete();
    last_addr = rd_addr;
    while (got_n < n && cyc < 100) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (done) done_seen++;
      if (rd_addr != last_addr) begin
        addr_log.push_back(rd_addr);
        last_addr = rd_addr;
      end
      out_ready = toggle ? !((cyc % 4 == 1) || (cyc % 4 == 2)) : 1'b1;
      if (out_valid && out_ready) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        got_cyc[got_n]  = cyc;
        got_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check("word_count", 32'(got_n), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
    mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h33; mem[5] = 8'h44;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; length = '0;
    repeat (3) tick();
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset_n = 1'b1;
    tick();

`ifdef READER_LOOP_EN
    start_xfer(4'h0, 5'd2);
    check("loop_busy", 32'(busy), 32'd1);
    tick();
    stream(6, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("loop_data", 32'(got_data[i]), 32'(mem[i % 2]));
      check("loop_last", 32'(got_last[i]), 32'(i % 2));
    end
    check("loop_done_count", 32'(done_seen), 32'd2);
    check("loop_done_pulse", 32'(done), 32'd1);
    check("loop_busy_held", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("loop_abort_valid", 32'(out_valid), 32'd0);
    check("loop_abort_busy", 32'(busy), 32'd0);
    check("loop_abort_done", 32'(done), 32'd0);
`else
    // Full-rate single pass
    start_xfer(4'h2, 5'd4);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("t1_rd_addr_base", 32'(rd_addr), 32'h2);
    check("t1_valid_n1", 32'(out_valid), 32'd0);
    stream(4, 1'b0);
    check("t1_w0", 32'(got_data[0]), 32'h11);
    check("t1_w1", 32'(got_data[1]), 32'h22);
    check("t1_w2", 32'(got_data[2]), 32'h33);
    check("t1_w3", 32'(got_data[3]), 32'h44);
    check("t1_latency", 32'(got_cyc[0]), 32'd1);
    check("t1_back_to_back", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
    for (int i = 0; i < 4; i++) check("t1_last", 32'(got_last[i]), 32'(i == 3));
    check("t1_done_early", 32'(done_seen), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_valid_low", 32'(out_valid), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done), 32'd0);

    // Backpressure with ready pattern 1,0,0,1
    start_xfer(4'h2, 5'd4);
    tick();
    stream(4, 1'b1);
    check("t2_w0", 32'(got_data[0]), 32'h11);
    check("t2_w1", 32'(got_data[1]), 32'h22);
    check("t2_w2", 32'(got_data[2]), 32'h33);
    check("t2_w3", 32'(got_data[3]), 32'h44);
    check("t2_last3", 32'(got_last[3]), 32'd1);
    check("t2_last0", 32'(got_last[0]), 32'd0);
    check("t2_done", 32'(done), 32'd1);
    tick();

    // Start while busy is ignored
    start_xfer(4'h2, 5'd4);
    base_addr = 4'h9; length = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    stream(4, 1'b0);
    check("t3_ignored_w0", 32'(got_data[0]), 32'h11);
    check("t3_ignored_w3", 32'(got_data[3]), 32'h44);
    check("t3_done", 32'(done), 32'd1);
    tick();

    // Address wrap
    start_xfer(4'hE, 5'd3);
    tick();
    check("t4_rd_addr_E", 32'(rd_addr), 32'hE);
    stream(3, 1'b0);
    check("t4_addr_log_len", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      check("t4_addr_F", 32'(addr_log[0]), 32'hF);
      check("t4_addr_0", 32'(addr_log[1]), 32'h0);
    end
    check("t4_w0", 32'(got_data[0]), 32'h8E);
    check("t4_w1", 32'(got_data[1]), 32'h8F);
    check("t4_w2", 32'(got_data[2]), 32'h80);
    check("t4_last", 32'(got_last[2]), 32'd1);
    tick();

    // Zero length
    start_xfer(4'h3, 5'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd1);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid || done || busy) vcount++;
    end
    check("t5_quiet_after", 32'(vcount), 32'd0);

    // Abort on the 5th word of a 16-word pass, then a fresh 1-word pass
    start_xfer(4'h0, 5'd16);
    tick();
    stream(4, 1'b0);
    check("t6_w3", 32'(got_data[3]), 32'h22);
    check("t6_5th_valid", 32'(out_valid), 32'd1);
    check("t6_5th_data", 32'(out_data), 32'h33);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_valid", 32'(out_valid), 32'd0);
    check("t6_abort_busy", 32'(busy), 32'd0);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || out_valid) vcount++;
      tick();
    end
    check("t6_no_done", 32'(vcount), 32'd0);
    start_xfer(4'h0, 5'd1);
    tick();
    stream(1, 1'b0);
    check("t6_new_w0", 32'(got_data[0]), 32'h80);
    check("t6_new_last", 32'(got_last[0]), 32'd1);
    check("t6_new_done", 32'(done), 32'd1);
    tick();

    // Reset mid-transfer, then a new pass
    start_xfer(4'h2, 5'd4);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_addr", 32'(rd_addr), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    start_xfer(4'h4, 5'd2);
    tick();
    stream(2, 1'b0);
    check("t7_w0", 32'(got_data[0]), 32'h33);
    check("t7_w1", 32'(got_data[1]), 32'h44);
    check("t7_done", 32'(done), 32'd1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
